// File: rtl/sys_bridge_pkg.sv
// Shared types and constants for the sys_bridge processor-to-memory/device bridge.
// States, address regions, default device window bases and the error read pattern.
package sys_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_DEV  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        RGN_MEM  = 2'd0,
        RGN_DEV0 = 2'd1,
        RGN_DEV1 = 2'd2,
        RGN_NONE = 2'd3
    } region_t;

    localparam logic [31:0] DEV0_BASE_DEFAULT = 32'h0000_7F00;
    localparam logic [31:0] DEV1_BASE_DEFAULT = 32'h0000_7F10;
    localparam logic [31:0] ERR_RDATA         = 32'hDEAD_BEEF;

    // Device windows are 16 bytes and aligned, so only bits [31:4] identify one.
    function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base);
        return addr[31:4] == base[31:4];
    endfunction

endpackage

// File: rtl/bridge_addr_decode.sv
// Combinational address decoder for sys_bridge: byte address -> target region
// plus word offset inside a 16-byte device window.
module bridge_addr_decode
    import sys_bridge_pkg::*;
#(
    parameter int          MEM_AW    = 14,
    parameter logic [31:0] DEV0_BASE = DEV0_BASE_DEFAULT,
    parameter logic [31:0] DEV1_BASE = DEV1_BASE_DEFAULT
) (
    input  logic [31:0] addr,
    output region_t     region,
    output logic [1:0]  word_off
);

    // Byte lanes are selected by the byte enables, never by the low address bits.
    logic unused_lane_bits;
    assign unused_lane_bits = ^addr[1:0];

    always_comb begin
        // NOTE: default assignment first so every path drives region and no latch is inferred.
        region = RGN_NONE;
        if (addr[31:MEM_AW] == '0) begin
            region = RGN_MEM;
        end else if (in_window(addr, DEV0_BASE)) begin
            region = RGN_DEV0;
        end else if (in_window(addr, DEV1_BASE)) begin
            region = RGN_DEV1;
        end
    end

    assign word_off = addr[3:2];

endmodule

// File: rtl/sys_bridge.sv
// Single-outstanding bus bridge between the core memory port, synchronous RAM and two
// memory-mapped devices. Define BRIDGE_TIMEOUT_EN to add a device acknowledge timeout.
module sys_bridge
    import sys_bridge_pkg::*;
#(
    parameter int          MEM_AW         = 14,
    parameter int          MEM_WAIT       = 1,
    parameter logic [31:0] DEV0_BASE      = DEV0_BASE_DEFAULT,
    parameter logic [31:0] DEV1_BASE      = DEV1_BASE_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pr_addr,
    input  logic [31:0]       pr_wdata,
    input  logic [3:0]        pr_be,
    input  logic              pr_we,
    input  logic              pr_req,
    output logic [31:0]       pr_rdata,
    output logic              pr_ready,
    output logic              bus_err,
    output logic [4:0]        hw_int,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        dev_sel,
    output logic              dev_we,
    output logic [1:0]        dev_addr,
    output logic [3:0]        dev_be,
    output logic [31:0]       dev_wdata,
    input  logic [31:0]       dev_rdata0,
    input  logic [31:0]       dev_rdata1,
    input  logic [1:0]        dev_ack,
    input  logic [4:0]        dev_irq
);

    localparam int WAIT_W = $clog2(MEM_WAIT + 1);

    state_t            state, state_nxt;
    region_t           dec_region, region_q;
    logic [1:0]        dec_off, off_q;
    logic [MEM_AW-3:0] waddr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              we_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              mem_last;
    logic              dev_hit;
    logic [31:0]       dev_rd;

    bridge_addr_decode #(
        .MEM_AW    (MEM_AW),
        .DEV0_BASE (DEV0_BASE),
        .DEV1_BASE (DEV1_BASE)
    ) u_decode (
        .addr     (pr_addr),
        .region   (dec_region),
        .word_off (dec_off)
    );

    assign mem_last = (wait_cnt == WAIT_W'(MEM_WAIT));
    assign dev_hit  = (region_q == RGN_DEV0) ? dev_ack[0] : dev_ack[1];
    assign dev_rd   = (region_q == RGN_DEV0) ? dev_rdata0 : dev_rdata1;

`ifdef BRIDGE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;
    logic            to_expired;
    assign to_expired = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, ERR_RDATA};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        dev_sel   = 2'b00;
        dev_we    = 1'b0;
        pr_ready  = 1'b0;
        bus_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pr_req) begin
                    case (dec_region)
                        RGN_MEM:            state_nxt = ST_MEM;
                        RGN_DEV0, RGN_DEV1: state_nxt = ST_DEV;
                        default:            state_nxt = ST_RESP;
                    endcase
                end
            end
            ST_MEM: begin
                // The RAM is strobed once on entry; the remaining cycles only wait for data.
                mem_en = (wait_cnt == '0);
                mem_we = mem_en & we_q;
                if (mem_last) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_DEV: begin
                dev_sel = (region_q == RGN_DEV0) ? 2'b01 : 2'b10;
                dev_we  = we_q;
                if (dev_hit) begin
                    state_nxt = ST_RESP;
                end
`ifdef BRIDGE_TIMEOUT_EN
                else if (to_expired) begin
                    state_nxt = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                pr_ready  = 1'b1;
                bus_err   = err_q;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the datapath is reset as well, so pr_rdata and hw_int read 0 straight out of reset.
        if (reset) begin
            region_q <= RGN_NONE;
            off_q    <= 2'b00;
            waddr_q  <= '0;
            wdata_q  <= '0;
            be_q     <= 4'b0000;
            we_q     <= 1'b0;
            wait_cnt <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            hw_int   <= 5'b00000;
`ifdef BRIDGE_TIMEOUT_EN
            to_cnt   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            hw_int <= dev_irq;
            case (state)
                ST_IDLE: begin
                    if (pr_req) begin
                        region_q <= dec_region;
                        off_q    <= dec_off;
                        waddr_q  <= pr_addr[MEM_AW-1:2];
                        wdata_q  <= pr_wdata;
                        be_q     <= pr_be;
                        we_q     <= pr_we;
                        wait_cnt <= '0;
                        rdata_q  <= '0;
                        err_q    <= (dec_region == RGN_NONE);
`ifdef BRIDGE_TIMEOUT_EN
                        to_cnt   <= '0;
`endif
                    end
                end
                ST_MEM: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (mem_last && !we_q) begin
                        rdata_q <= mem_rdata;
                    end
                end
                ST_DEV: begin
                    if (dev_hit) begin
                        if (!we_q) begin
                            rdata_q <= dev_rd;
                        end
                    end
`ifdef BRIDGE_TIMEOUT_EN
                    else if (to_expired) begin
                        rdata_q <= ERR_RDATA;
                        err_q   <= 1'b1;
                    end
                    to_cnt <= to_cnt + 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign pr_rdata  = rdata_q;
    assign mem_addr  = waddr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign dev_addr  = off_q;
    assign dev_be    = be_q;
    assign dev_wdata = wdata_q;

endmodule

// File: doc/sys_bridge.md
Name: sys_bridge

Overview:
- Bus bridge directly downstream of the multicycle processor core's memory port.
- Accepts one request at a time (addr/wdata/BE/WE/Req), decodes the address, and drives either the synchronous main RAM or one of two memory-mapped devices.
- Returns read data with a one-cycle Ready pulse.
- Registers device interrupt lines into the core's 5-bit HW_Int input.

Parameters:
- MEM_AW, 14, RAM byte-address width; RAM occupies 0x0 .. 2^MEM_AW-1.
- MEM_WAIT, 1, cycles from mem_en to valid mem_rdata (>=1).
- DEV0_BASE, 32'h0000_7F00, device 0 window base (16 bytes).
- DEV1_BASE, 32'h0000_7F10, device 1 window base (16 bytes).
- TIMEOUT_CYCLES, 16, device ack timeout (used only with the optional feature).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- pr_addr  in  32  processor byte address.
- pr_wdata  in  32  write data.
- pr_be  in  4  byte enables.
- pr_we  in  1  write strobe, qualifies pr_req.
- pr_req  in  1  request; held high by the core until pr_ready.
- pr_rdata  out  32  read data, valid while pr_ready=1.
- pr_ready  out  1  one-cycle completion pulse.
- bus_err  out  1  one-cycle pulse with pr_ready on an unmapped or timed-out access.
- hw_int  out  5  registered interrupt lines to the core.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write.
- mem_addr  out  MEM_AW-2  RAM word address.
- mem_be  out  4  byte enables to RAM.
- mem_wdata  out  32  RAM write data.
- mem_rdata  in  32  RAM read data.
- dev_sel  out  2  one-hot device select, held until ack.
- dev_we  out  1  device write.
- dev_addr  out  2  word offset in the device window.
- dev_be  out  4  byte enables to device.
- dev_wdata  out  32  device write data.
- dev_rdata0  in  32  device 0 read data.
- dev_rdata1  in  32  device 1 read data.
- dev_ack  in  2  per-device acknowledge.
- dev_irq  in  5  raw device interrupt lines.

Behaviour:
- Reset: state IDLE. pr_ready, bus_err, mem_en, mem_we, dev_sel, dev_we, hw_int and pr_rdata all 0. Reset mid-access abandons the transaction; no Ready is issued.
- FSM states: IDLE, MEM, DEV, RESP.
- IDLE:
  - On pr_req=1, latch addr, wdata, be and we; pr_addr[1:0] is ignored and pr_be selects lanes.
  - Decode is priority-free; windows are disjoint.
  - RAM hit (addr < 2^MEM_AW) -> MEM.
  - DEV0 or DEV1 window -> DEV.
  - Otherwise -> RESP with bus_err=1 and rdata=0; a write is discarded.
- MEM:
  - mem_en=1 (mem_we=latched we) on the entry cycle only, then count MEM_WAIT cycles.
  - On the final count, capture mem_rdata for a read and go to RESP.
  - Total: pr_ready high exactly MEM_WAIT+2 cycles after the IDLE sampling edge.
- DEV:
  - Hold dev_sel, dev_we, dev_addr=addr[3:2], dev_be and dev_wdata stable until the selected dev_ack bit is 1.
  - On ack, capture the matching dev_rdata for a read and go to RESP.
  - Ack on the non-selected device is ignored.
- RESP:
  - pr_ready=1 for exactly one cycle; pr_rdata holds the captured value (0 for writes); then IDLE.
  - pr_req is not sampled in RESP, so a back-to-back request is accepted the following IDLE cycle.
- pr_be=4'b0000: the access completes normally and mem_be/dev_be=0.
- hw_int <= dev_irq every cycle, so there is one cycle of latency. Level, not latched; clearing is the device's responsibility.
- No outstanding-request queue: exactly one transaction is in flight.

Optional Feature:
- Macro BRIDGE_TIMEOUT_EN.
- Defined: a counter runs in DEV. If no ack arrives within TIMEOUT_CYCLES cycles, drop dev_sel and go to RESP with bus_err=1 and pr_rdata=32'hDEAD_BEEF.
- Undefined: DEV waits indefinitely, no counter is synthesized, and bus_err fires only for unmapped addresses.

Decomposition:
- Shared package holds:
  - state encoding typedef (IDLE/MEM/DEV/RESP);
  - region enum (RGN_MEM/RGN_DEV0/RGN_DEV1/RGN_NONE);
  - default window bases;
  - the 32'hDEAD_BEEF error constant.
- One natural sub-module, bridge_addr_decode: combinational addr -> region plus word offset, unit-tested alone.

Test Plan:
- RAM word write then read: write addr 0x10, wdata 0x1234_5678, be 1111; read 0x10 -> rdata 0x1234_5678, pr_ready at cycle MEM_WAIT+2 (3 for default), bus_err=0.
- Byte write: be 0100 with wdata 0x00AB_0000 at 0x20 over 0xFFFF_FFFF -> mem_be=0100; read returns 0xFFAB_FFFF.
- Device read with slow ack: read 0x7F14, dev_ack[1] after 5 cycles -> dev_sel=10 and dev_addr=01 held 5 cycles, then pr_rdata=dev_rdata1, one Ready pulse.
- Unmapped read 0x8000_0000 -> Ready with rdata 0, bus_err=1; no mem_en or dev_sel activity.
- Reset asserted while in DEV -> next cycle IDLE, dev_sel=0, no pr_ready.
- With BRIDGE_TIMEOUT_EN, a read of 0x7F00 with no ack -> Ready after 16 DEV cycles, rdata 0xDEAD_BEEF, bus_err=1. Separately, dev_irq=5'b00101 -> hw_int=5'b00101 one cycle later.
